// File: rtl/h_u_csatm8_mac_acc.sv
// Multiply-accumulate over a counted burst of 8x8 truncated (k=4) products with a sticky overflow flag.
// Optional MAC_ACC_SATURATE_EN: clamp acc to all-ones on overflow instead of wrapping.
module h_u_csatm8_mac_acc #(
  parameter int ACC_W = 20,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] cnt;
  logic [15:0]      prod_r;
  logic             prod_vld;
  logic [ACC_W-1:0] acc_r;
  logic             ovf_r;
  logic             accept;
  logic [7:0]       hi_prod;
  logic [ACC_W:0]   sum;

  // Only the upper nibbles survive truncation; low product byte is structurally zero.
  assign hi_prod = {4'h0, a[7:4]} * {4'h0, b[7:4]};
  assign sum     = {1'b0, acc_r} + (ACC_W+1)'(prod_r);
  assign accept  = in_valid & in_ready;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? DONE : RUN;
      RUN:     if (accept && cnt == LEN_W'(1)) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      RUN:     in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      prod_r   <= '0;
      prod_vld <= 1'b0;
      acc_r    <= '0;
      ovf_r    <= 1'b0;
    end else if (state == IDLE && start) begin
      cnt      <= len;
      prod_vld <= 1'b0;
      acc_r    <= '0;
      ovf_r    <= 1'b0;
    end else begin
      prod_vld <= accept;
      if (accept) begin
        cnt    <= cnt - LEN_W'(1);
        prod_r <= {hi_prod, 8'h00};
      end
      // Stage two: the product captured on the previous accept edge lands in acc.
      if (prod_vld) begin
        if (sum[ACC_W]) ovf_r <= 1'b1;
`ifdef MAC_ACC_SATURATE_EN
        acc_r <= (ovf_r || sum[ACC_W]) ? '1 : sum[ACC_W-1:0];
`else
        acc_r <= sum[ACC_W-1:0];
`endif
      end
    end
  end

  assign acc = acc_r;
  assign ovf = ovf_r;

endmodule

// File: tb/tb_h_u_csatm8_mac_acc.sv
// Randomized and directed bench for h_u_csatm8_mac_acc against a sum-of-products reference model.
module tb_h_u_csatm8_mac_acc;
  localparam int ACC_W = 20;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       a = '0;
  logic [7:0]       b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] acc;
  logic             ovf;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] va[$];
  logic [7:0] vb[$];

  always #5 clk = ~clk;

  h_u_csatm8_mac_acc #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .acc(acc), .ovf(ovf)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: total of (a_hi*b_hi)*256; overflow iff the true total reaches 2^ACC_W.
  function automatic void model(output longint e_acc, output bit e_ovf);
    longint s = 0;
    longint lim = longint'(1) << ACC_W;
    foreach (va[i]) s += longint'(va[i] / 16) * longint'(vb[i] / 16) * 256;
    e_ovf = (s >= lim);
`ifdef MAC_ACC_SATURATE_EN
    e_acc = e_ovf ? lim - 1 : s;
`else
    e_acc = s % lim;
`endif
  endfunction

  task automatic push_ff(input int n);
    va.delete(); vb.delete();
    for (int i = 0; i < n; i++) begin va.push_back(8'hFF); vb.push_back(8'hFF); end
  endtask

  task automatic push_rand(input int n);
    va.delete(); vb.delete();
    for (int i = 0; i < n; i++) begin
      va.push_back(8'($urandom)); vb.push_back(8'($urandom));
    end
  endtask

  // Runs one accumulation over va/vb; gap is the percentage of bubble cycles, hold the DONE stall length.
  task automatic run_txn(input string tag, input int gap, input int hold);
    int n = va.size();
    int idx = 0;
    int budget = 0;
    bit take;
    longint e_acc;
    bit e_ovf;
    model(e_acc, e_ovf);
    @(negedge clk); start = 1'b1; len = LEN_W'(n);
    @(negedge clk); start = 1'b0;
    if (n == 0) begin
      check({tag, "_zero_ov"}, out_valid, 1);
      check({tag, "_zero_rdy"}, in_ready, 0);
    end else begin
      while (idx < n && budget < 2000) begin
        in_valid = ($urandom_range(99) >= gap);
        a = va[idx]; b = vb[idx];
        take = in_valid && in_ready;
        @(posedge clk);
        if (take) idx++;
        @(negedge clk);
        budget++;
      end
      in_valid = 1'b0;
      if (idx < n) begin
        check({tag, "_accept_timeout"}, idx, n);
        return;
      end
      check({tag, "_drain_ov"}, out_valid, 0);
      check({tag, "_drain_rdy"}, in_ready, 0);
      @(posedge clk); #1;
      check({tag, "_done_lat"}, out_valid, 1);
    end
    check({tag, "_acc"}, acc, e_acc);
    check({tag, "_ovf"}, ovf, e_ovf);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); start = 1'b1; len = LEN_W'(3);
      check({tag, "_hold_ov"}, out_valid, 1);
      check({tag, "_hold_acc"}, acc, e_acc);
      check({tag, "_hold_rdy"}, in_ready, 0);
    end
    @(negedge clk); start = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_idle_ov"}, out_valid, 0);
    check({tag, "_idle_rdy"}, in_ready, 0);
  endtask

  initial begin
    #12;
    check("rst_acc", acc, 0);
    check("rst_ovf", ovf, 0);
    check("rst_ov", out_valid, 0);
    check("rst_rdy", in_ready, 0);
    @(negedge clk); rst_n = 1'b1;

    push_ff(1);
    run_txn("one_ff", 0, 0);

    va = '{8'h0F, 8'h10, 8'h80};
    vb = '{8'hFF, 8'h10, 8'h30};
    run_txn("three_gap", 50, 0);

    va.delete(); vb.delete();
    run_txn("len0", 0, 0);

    push_ff(20);
    run_txn("ovf20", 20, 0);

    push_rand(4);
    run_txn("stall", 30, 5);

    for (int t = 0; t < 20; t++) begin
      push_rand($urandom_range(1, 25));
      run_txn($sformatf("rnd%0d", t), 40, $urandom_range(0, 2));
    end

    // Reset in the middle of a 4-beat run.
    @(negedge clk); start = 1'b1; len = LEN_W'(4);
    @(negedge clk); start = 1'b0; in_valid = 1'b1; a = 8'hFF; b = 8'hFF;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_acc", acc, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_rdy", in_ready, 0);
    check("mid_rst_ov", out_valid, 0);
    repeat (2) @(posedge clk);
    #1 check("in_rst_rdy", in_ready, 0);
    check("in_rst_acc", acc, 0);
    @(negedge clk); in_valid = 1'b0; rst_n = 1'b1;
    push_ff(1);
    run_txn("post_rst", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
